// File: rtl/lab2_proc_muldiv_iter.sv
// Iterative RV32M multiply/divide unit for the X stage, with a val/rdy stream on each side.
// Multiplies use shift-add with optional zero-skip; divides use a restoring algorithm.
module lab2_proc_muldiv_iter #(
  parameter int unsigned p_nbits      = 32,
  parameter int unsigned p_skip_zeros = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2:0]         istream_fn,
  input  logic [p_nbits-1:0] istream_a,
  input  logic [p_nbits-1:0] istream_b,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg
);

  localparam int unsigned NB = p_nbits;
  localparam int unsigned WB = 2 * p_nbits;
  localparam int unsigned CW = $clog2(p_nbits);
  localparam logic [2:0] FN_MUL    = 3'd0;
  localparam logic [2:0] FN_MULH   = 3'd1;
  localparam logic [2:0] FN_MULHSU = 3'd2;
  localparam logic [2:0] FN_DIV    = 3'd4;
  localparam logic [2:0] FN_REM    = 3'd6;
  localparam logic [NB-1:0] MIN_NEG = NB'(1) << (NB - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic            rdy_q, rdy_d, val_q, val_d;
  logic [NB-1:0]   msg_q, msg_d;
  logic [2:0]      fn_q, fn_d;
  logic            neg_q, neg_d, rneg_q, rneg_d;
  logic [WB-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [NB-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Request decode: operand magnitudes, signs and the divides resolved without iterating
  logic          in_div, sa_in, sb_in, a_neg, b_neg, in_special;
  logic [NB-1:0] a_mag, b_mag, special_res;
  always_comb begin
    in_div      = istream_fn[2];
    sa_in       = istream_fn inside {FN_MUL, FN_MULH, FN_MULHSU, FN_DIV, FN_REM};
    sb_in       = istream_fn inside {FN_MUL, FN_MULH, FN_DIV, FN_REM};
    a_neg       = sa_in & istream_a[NB-1];
    b_neg       = sb_in & istream_b[NB-1];
    a_mag       = a_neg ? NB'(0) - istream_a : istream_a;
    b_mag       = b_neg ? NB'(0) - istream_b : istream_b;
    in_special  = 1'b0;
    special_res = '0;
    if (in_div && (istream_b == '0)) begin
      in_special  = 1'b1;
      special_res = istream_fn[1] ? istream_a : '1;
    end else if (in_div && !istream_fn[0] && (istream_a == MIN_NEG) && (istream_b == '1)) begin
      in_special  = 1'b1;
      special_res = istream_fn[1] ? '0 : istream_a;
    end
  end

  // One iteration of either algorithm plus the sign fix-up applied on the final step
  logic          is_div, last, div_fit;
  logic [WB-1:0] mul_acc, prod, div_acc;
  logic [NB:0]   div_up;
  logic [NB-1:0] mplier_sh, div_rem, quot, rem, mul_res, div_res;
  always_comb begin
    is_div    = fn_q[2];
    mul_acc   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    mplier_sh = mplier_q >> 1;
    prod      = neg_q ? WB'(0) - mul_acc : mul_acc;
    mul_res   = (fn_q == FN_MUL) ? prod[NB-1:0] : prod[WB-1:NB];
    div_up    = acc_q[WB-1:NB-1];
    div_fit   = div_up >= {1'b0, mcand_q[NB-1:0]};
    div_rem   = div_fit ? NB'(div_up - {1'b0, mcand_q[NB-1:0]}) : div_up[NB-1:0];
    div_acc   = {div_rem, acc_q[NB-2:0], div_fit};
    quot      = div_acc[NB-1:0];
    rem       = div_acc[WB-1:NB];
    div_res   = fn_q[1] ? (rneg_q ? NB'(0) - rem : rem)
                        : (neg_q ? NB'(0) - quot : quot);
    last      = (cnt_q == CW'(NB - 1)) ||
                (!is_div && (p_skip_zeros != 0) && (mplier_sh == '0));
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    fn_d     = fn_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (istream_val && rdy_q) begin
          fn_d     = istream_fn;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          cnt_d    = '0;
          acc_d    = in_div ? {{NB{1'b0}}, a_mag} : '0;
          mcand_d  = {{NB{1'b0}}, in_div ? b_mag : a_mag};
          mplier_d = b_mag;
          if (in_special) begin
            msg_d   = special_res;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div) begin
          acc_d = div_acc;
        end else begin
          acc_d    = mul_acc;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_sh;
        end
        if (last) begin
          msg_d   = is_div ? div_res : mul_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ostream_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
    val_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rdy_q    <= 1'b0;
      val_q    <= 1'b0;
      msg_q    <= '0;
      fn_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      val_q    <= val_d;
      msg_q    <= msg_d;
      fn_q     <= fn_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign istream_rdy = rdy_q;
  assign ostream_val = val_q;
  assign ostream_msg = msg_q;

endmodule
